// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM arbiter: FSM states, port index and port count.
package sdram_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    typedef logic [0:0] port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the two request ports and the SDRAM-controller handshake.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
);
    logic                  p0_valid;
    logic [ADDR_W-1:0]     p0_addr;
    logic [DATA_W-1:0]     p0_wdata;
    logic [DATA_W/8-1:0]   p0_wmask;
    logic [DATA_W-1:0]     p0_rdata;
    logic                  p0_ready;

    logic                  p1_valid;
    logic [ADDR_W-1:0]     p1_addr;
    logic [DATA_W-1:0]     p1_wdata;
    logic [DATA_W/8-1:0]   p1_wmask;
    logic [DATA_W-1:0]     p1_rdata;
    logic                  p1_ready;

    logic                  sd_valid;
    logic [ADDR_W-1:0]     sd_addr;
    logic [DATA_W-1:0]     sd_din;
    logic [DATA_W/8-1:0]   sd_wmask;
    logic [DATA_W-1:0]     sd_dout;
    logic                  sd_ready;

    modport master (
        input  p0_valid, p0_addr, p0_wdata, p0_wmask,
        output p0_rdata, p0_ready,
        input  p1_valid, p1_addr, p1_wdata, p1_wmask,
        output p1_rdata, p1_ready,
        output sd_valid, sd_addr, sd_din, sd_wmask,
        input  sd_dout, sd_ready
    );

    modport slave (
        output p0_valid, p0_addr, p0_wdata, p0_wmask,
        input  p0_rdata, p0_ready,
        output p1_valid, p1_addr, p1_wdata, p1_wmask,
        input  p1_rdata, p1_ready,
        input  sd_valid, sd_addr, sd_din, sd_wmask,
        output sd_dout, sd_ready
    );

endinterface

// File: rtl/sdram_arbiter_pick.sv
// Combinational grant selection between the two ports.
// SDRAM_ARB_RR_EN: round-robin tie-break on last grant; otherwise port 0 always wins.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] valid,
`ifdef SDRAM_ARB_RR_EN
    input  port_idx_t            last_grant,
`endif
    output logic                 req_any,
    output port_idx_t            pick
);

    // Winner among the requesting ports
    always_comb begin
        req_any = |valid;
        pick    = PORT0;
        if (valid[0] && valid[1]) begin
`ifdef SDRAM_ARB_RR_EN
            if (last_grant == PORT0) begin
                pick = PORT1;
            end else begin
                pick = PORT0;
            end
`else
            pick = PORT0;
`endif
        end else if (valid[1]) begin
            pick = PORT1;
        end else begin
            pick = PORT0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single SDRAM controller handshake.
// Arbitration policy selected by SDRAM_ARB_RR_EN (round-robin when defined, fixed p0 priority otherwise).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    sdram_arbiter_if.master  bus
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] ADDR_ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

    arb_state_t          state_r;
    arb_state_t          state_next;
    port_idx_t           grant_r;
    port_idx_t           pick_s;
    logic                pick_any_s;
    logic                grant_en_s;
    logic                done_s;

    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic [MASK_W-1:0]   sel_wmask_s;

    logic                sd_valid_r;
    logic [ADDR_W-1:0]   sd_addr_r;
    logic [DATA_W-1:0]   sd_din_r;
    logic [MASK_W-1:0]   sd_wmask_r;
    logic [DATA_W-1:0]   p0_rdata_r;
    logic [DATA_W-1:0]   p1_rdata_r;
    logic                p0_ready_r;
    logic                p1_ready_r;

`ifdef SDRAM_ARB_RR_EN
    port_idx_t           last_r;

    // Remembers the most recent winner for the round-robin tie-break
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= PORT1;
        end else if (grant_en_s) begin
            last_r <= pick_s;
        end
    end
`endif

    sdram_arb_pick u_pick (
        .valid      ({bus.p1_valid, bus.p0_valid}),
`ifdef SDRAM_ARB_RR_EN
        .last_grant (last_r),
`endif
        .req_any    (pick_any_s),
        .pick       (pick_s)
    );

    // Request fields of the port about to be granted
    always_comb begin
        sel_addr_s  = bus.p0_addr;
        sel_wdata_s = bus.p0_wdata;
        sel_wmask_s = bus.p0_wmask;
        if (pick_s == PORT1) begin
            sel_addr_s  = bus.p1_addr;
            sel_wdata_s = bus.p1_wdata;
            sel_wmask_s = bus.p1_wmask;
        end else begin
            sel_addr_s  = bus.p0_addr;
            sel_wdata_s = bus.p0_wdata;
            sel_wmask_s = bus.p0_wmask;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic; a grant in IDLE waits until the controller has dropped sd_ready
    always_comb begin
        state_next = state_r;
        grant_en_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.sd_ready && pick_any_s) begin
                    state_next = REQ;
                    grant_en_s = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            REQ: begin
                if (bus.sd_ready) begin
                    state_next = REL;
                    done_s     = 1'b1;
                end else begin
                    state_next = REQ;
                end
            end
            REL: begin
                if (!bus.sd_ready) begin
                    state_next = DONE;
                end else begin
                    state_next = REL;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request/response datapath and the one-cycle ready pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r    <= PORT0;
            sd_valid_r <= 1'b0;
            sd_addr_r  <= {ADDR_W{1'b0}};
            sd_din_r   <= {DATA_W{1'b0}};
            sd_wmask_r <= {MASK_W{1'b0}};
            p0_rdata_r <= {DATA_W{1'b0}};
            p1_rdata_r <= {DATA_W{1'b0}};
            p0_ready_r <= 1'b0;
            p1_ready_r <= 1'b0;
        end else begin
            if (grant_en_s) begin
                grant_r    <= pick_s;
                sd_valid_r <= 1'b1;
                sd_addr_r  <= sel_addr_s & ADDR_ALIGN;
                sd_din_r   <= sel_wdata_s;
                sd_wmask_r <= sel_wmask_s;
            end else if (done_s) begin
                sd_valid_r <= 1'b0;
                sd_wmask_r <= {MASK_W{1'b0}};
            end
            // A zero mask marks a read; only reads update the port's rdata
            if (done_s && (sd_wmask_r == {MASK_W{1'b0}})) begin
                if (grant_r == PORT1) begin
                    p1_rdata_r <= bus.sd_dout;
                end else begin
                    p0_rdata_r <= bus.sd_dout;
                end
            end
            p0_ready_r <= (state_next == DONE) && (grant_r == PORT0);
            p1_ready_r <= (state_next == DONE) && (grant_r == PORT1);
        end
    end

    assign bus.sd_valid = sd_valid_r;
    assign bus.sd_addr  = sd_addr_r;
    assign bus.sd_din   = sd_din_r;
    assign bus.sd_wmask = sd_wmask_r;
    assign bus.p0_rdata = p0_rdata_r;
    assign bus.p1_rdata = p1_rdata_r;
    assign bus.p0_ready = p0_ready_r;
    assign bus.p1_ready = p1_ready_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: table of single transactions plus contention,
// slow-release and mid-transfer reset sequences. Honours SDRAM_ARB_RR_EN for expectations.
module tb_sdram_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int                port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wmask;
        logic [DATA_W-1:0] dout;
        int                lat;
        int                hold;
        logic [ADDR_W-1:0] exp_sd_addr;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    int n_chk = 0;
    int n_fail = 0;
    int cnt0 = 0;
    int cnt1 = 0;

    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_din;
    logic [3:0]        g_wmask;
    logic              rel_valid;
    logic [3:0]        rel_wmask;
    logic              stable;
    logic              early;
    logic [DATA_W-1:0] exp_rd [2];

    // Ready-pulse counters, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.p0_ready === 1'b1) cnt0++;
        if (bus.p1_ready === 1'b1) cnt1++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_wmask = 4'h0;
        bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_wmask = 4'h0;
        bus.sd_ready = 1'b0; bus.sd_dout = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Controller model: wait for a grant, answer after lat cycles, keep sd_ready high
    // for hold extra cycles after sd_valid drops, then wait for the ready pulse.
    task automatic serve(input int lat, input int hold, input logic [DATA_W-1:0] dout,
                         output int port, output int cyc);
        int n;
        int c0;
        int c1;
        port = -1; cyc = 0; stable = 1'b1; early = 1'b0;
        n = 0;
        while (bus.sd_valid !== 1'b1 && n < 20) begin
            step(); n++;
        end
        cyc = n;
        if (bus.sd_valid !== 1'b1) begin
            chk("grant_timeout", 64'd0, 64'd1);
            return;
        end
        g_addr = bus.sd_addr; g_din = bus.sd_din; g_wmask = bus.sd_wmask;
        c0 = cnt0; c1 = cnt1;
        // Port inputs change after the grant; the arbiter must ignore them
        bus.p0_addr = ~bus.p0_addr; bus.p0_wdata = ~bus.p0_wdata;
        bus.p1_addr = ~bus.p1_addr; bus.p1_wdata = ~bus.p1_wdata;
        for (int i = 1; i < lat; i++) begin
            step(); cyc++;
            if (bus.sd_valid !== 1'b1 || bus.sd_addr !== g_addr ||
                bus.sd_din !== g_din || bus.sd_wmask !== g_wmask) stable = 1'b0;
        end
        bus.sd_ready = 1'b1; bus.sd_dout = dout;
        step(); cyc++;
        rel_valid = bus.sd_valid; rel_wmask = bus.sd_wmask;
        for (int i = 0; i < hold; i++) begin
            step(); cyc++;
            if (bus.sd_valid !== 1'b0) stable = 1'b0;
        end
        if (cnt0 != c0 || cnt1 != c1) early = 1'b1;
        bus.sd_ready = 1'b0; bus.sd_dout = 32'h0BAD_0BAD;
        n = 0;
        while (bus.p0_ready !== 1'b1 && bus.p1_ready !== 1'b1 && n < 6) begin
            step(); cyc++; n++;
        end
        if (bus.p0_ready === 1'b1) port = 0;
        else if (bus.p1_ready === 1'b1) port = 1;
        else chk("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int port;
        int cyc;
        int c0;
        int c1;
        int n;
        int exp_seq [4];
        logic flag;

        vecs[0] = '{0, 25'h0000123, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 5, 0, 25'h0000120, 32'hDEAD_BEEF};
        vecs[1] = '{1, 25'h0000100, 32'hA5A5_A5A5, 4'hF, 32'h1111_1111, 2, 0, 25'h0000100, 32'h0000_0000};
        vecs[2] = '{1, 25'h1FFFFFF, 32'h0000_0000, 4'h0, 32'h1234_5678, 1, 0, 25'h1FFFFFC, 32'h1234_5678};
        vecs[3] = '{0, 25'h0000002, 32'h0000_BEEF, 4'h3, 32'h5555_5555, 3, 0, 25'h0000000, 32'hDEAD_BEEF};
        vecs[4] = '{0, 25'h0ABCDEF, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1, 3, 25'h0ABCDEC, 32'hCAFE_F00D};

        // Reset state
        idle_inputs();
        reset = 1'b1;
        step(); step();
        chk("rst_sd_valid", bus.sd_valid, 1'b0);
        chk("rst_sd_addr", bus.sd_addr, 25'h0);
        chk("rst_sd_din", bus.sd_din, 32'h0);
        chk("rst_sd_wmask", bus.sd_wmask, 4'h0);
        chk("rst_ready", {bus.p1_ready, bus.p0_ready}, 2'b00);
        chk("rst_rdata", {bus.p1_rdata, bus.p0_rdata}, 64'h0);
        reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        step();

        // Table-driven single transactions
        for (int k = 0; k < 5; k++) begin
            if (vecs[k].port == 0) begin
                bus.p0_addr = vecs[k].addr; bus.p0_wdata = vecs[k].wdata;
                bus.p0_wmask = vecs[k].wmask; bus.p0_valid = 1'b1;
            end else begin
                bus.p1_addr = vecs[k].addr; bus.p1_wdata = vecs[k].wdata;
                bus.p1_wmask = vecs[k].wmask; bus.p1_valid = 1'b1;
            end
            c0 = cnt0; c1 = cnt1;
            serve(vecs[k].lat, vecs[k].hold, vecs[k].dout, port, cyc);
            bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
            step();
            exp_rd[vecs[k].port] = vecs[k].exp_rdata;
            chk($sformatf("v%0d_port", k), port, vecs[k].port);
            chk($sformatf("v%0d_sd_addr", k), g_addr, vecs[k].exp_sd_addr);
            chk($sformatf("v%0d_sd_din", k), g_din, vecs[k].wdata);
            chk($sformatf("v%0d_sd_wmask", k), g_wmask, vecs[k].wmask);
            chk($sformatf("v%0d_stable", k), stable, 1'b1);
            chk($sformatf("v%0d_rel_valid", k), rel_valid, 1'b0);
            chk($sformatf("v%0d_rel_wmask", k), rel_wmask, 4'h0);
            chk($sformatf("v%0d_early_ready", k), early, 1'b0);
            chk($sformatf("v%0d_latency", k), cyc, vecs[k].lat + 2 + vecs[k].hold);
            chk($sformatf("v%0d_p0_rdata", k), bus.p0_rdata, exp_rd[0]);
            chk($sformatf("v%0d_p1_rdata", k), bus.p1_rdata, exp_rd[1]);
            chk($sformatf("v%0d_p0_pulses", k), cnt0 - c0, (vecs[k].port == 0) ? 1 : 0);
            chk($sformatf("v%0d_p1_pulses", k), cnt1 - c1, (vecs[k].port == 1) ? 1 : 0);
            chk($sformatf("v%0d_ready_low", k), {bus.p1_ready, bus.p0_ready}, 2'b00);
        end

        // Contention: both ports request continuously for four transactions
`ifdef SDRAM_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        do_reset();
        step();
        bus.p0_addr = 25'h10; bus.p0_valid = 1'b1;
        bus.p1_addr = 25'h20; bus.p1_valid = 1'b1;
        c0 = cnt0; c1 = cnt1;
        for (int k = 0; k < 4; k++) begin
            serve(1, 0, 32'h1000 + k, port, cyc);
            chk($sformatf("cont%0d_grant", k), port, exp_seq[k]);
            if (k == 3) begin
                bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
            end
            step();
        end
`ifdef SDRAM_ARB_RR_EN
        chk("cont_p1_pulses", cnt1 - c1, 2);
`else
        chk("cont_p1_pulses", cnt1 - c1, 0);
`endif
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.sd_valid !== 1'b0) flag = 1'b1;
        end
        chk("cont_no_extra_grant", flag, 1'b0);

        // Mid-transfer reset, then release with sd_ready still high from the controller
        bus.p1_addr = 25'h40; bus.p1_wmask = 4'h0; bus.p1_valid = 1'b1;
        n = 0;
        while (bus.sd_valid !== 1'b1 && n < 20) begin
            step(); n++;
        end
        chk("mrst_granted", bus.sd_valid, 1'b1);
        step();
        c0 = cnt0; c1 = cnt1;
        reset = 1'b1;
        step();
        chk("mrst_sd_valid", bus.sd_valid, 1'b0);
        chk("mrst_p1_rdata", bus.p1_rdata, 32'h0);
        reset = 1'b0;
        bus.sd_ready = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.sd_valid !== 1'b0) flag = 1'b1;
        end
        chk("mrst_no_grant_while_ready", flag, 1'b0);
        chk("mrst_no_pulse", (cnt0 - c0) + (cnt1 - c1), 0);
        bus.sd_ready = 1'b0;
        step();
        chk("mrst_grant_after_release", bus.sd_valid, 1'b1);
        chk("mrst_grant_addr", bus.sd_addr, 25'h40);
        serve(1, 0, 32'h0000_0077, port, cyc);
        bus.p1_valid = 1'b0;
        step();
        chk("mrst_port", port, 1);
        chk("mrst_rdata", bus.p1_rdata, 32'h0000_0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 25, SDRAM byte-address width; matches the sdram controller addr port.
REQ-002 Parameter: DATA_W, 32, data width; wmask width is DATA_W/8.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock (50 MHz); all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 p0_valid / p1_valid  in  1  request from port 0 (CPU) / port 1 (DMA); held high until the port's ready pulse.
REQ-007 p0_addr / p1_addr  in  ADDR_W  byte address; bits [1:0] ignored, forced to 0 toward SDRAM.
REQ-008 p0_wdata / p1_wdata  in  DATA_W  write data.
REQ-009 p0_wmask / p1_wmask  in  4  byte write strobes; 0 means read.
REQ-010 p0_rdata / p1_rdata  out  DATA_W  read data; valid in the ready cycle.
REQ-011 p0_ready / p1_ready  out  1  one-cycle completion pulse.
REQ-012 sd_valid, sd_addr, sd_din, sd_wmask  out  1/ADDR_W/DATA_W/4  registered request to the sdram controller.
REQ-013 sd_dout, sd_ready  in  DATA_W/1  controller response.

Function
REQ-014 FSM states: IDLE, REQ, REL, DONE.
REQ-015 IDLE: when sd_ready=0 and either pN_valid=1, grant one port, latch its addr/wdata/wmask into sd_* and set sd_valid=1 next cycle; go to REQ.
REQ-016 IDLE with sd_ready=1 (controller still releasing) issues no grant, whatever the port requests.
REQ-017 REQ: hold sd_valid=1 and all sd_* stable until sd_ready=1; on that cycle capture sd_dout into the granted pN_rdata if wmask was 0, clear sd_valid and sd_wmask, and go to REL.
REQ-018 REL: sd_valid=0; wait for sd_ready=0, then go to DONE.
REQ-019 DONE: assert the granted pN_ready for exactly one cycle, then go to IDLE; the non-granted port's ready stays 0.
REQ-020 Minimum latency from pN_valid sampled in IDLE to pN_ready: 3 cycles plus controller latency. A request never completes in fewer than 3 cycles.
REQ-021 Request inputs are sampled only in IDLE; changes on pN_* in other states are ignored.
REQ-022 pN_rdata holds its last captured value until the next read completes on that port.
REQ-023 Simultaneous p0_valid and p1_valid in IDLE follow the arbitration policy (REQ-029/030); the losing port is served in the next IDLE with sd_ready=0.
REQ-024 After a DONE, a port whose valid is still high is treated as a new request.

Reset
REQ-025 Reset: state IDLE; sd_valid=0, sd_wmask=0, sd_addr=0, sd_din=0; p0_ready=p1_ready=0; p0_rdata=p1_rdata=0; last-grant=port 1.
REQ-026 Reset during REQ/REL/DONE abandons the transfer: no ready pulse is issued, and sd_valid is 0 on the cycle after reset.
REQ-027 The first grant after reset waits for sd_ready=0 (REQ-016), so the controller finishes releasing an abandoned handshake first.

Configuration
REQ-028 Macro SDRAM_ARB_RR_EN selects the arbitration policy.
REQ-029 With SDRAM_ARB_RR_EN defined: round-robin. On a tie, the port not granted last wins, and last-grant updates on every grant.
REQ-030 Without SDRAM_ARB_RR_EN: fixed priority, port 0 wins every tie; no last-grant register is synthesized.

Structure
REQ-031 Package sdram_arb_pkg: FSM state enum, port-index type, and the constant for the number of ports (2).
REQ-032 Sub-module sdram_arb_pick: combinational grant selection from the valids and last-grant, policy set by SDRAM_ARB_RR_EN; the FSM and datapath stay in sdram_arbiter.

Verification
REQ-033 Single read: p0 read at addr 0x0000123, controller returns 0xDEADBEEF after 5 cycles -> sd_addr=0x0000120, sd_wmask=0, one p0_ready pulse, p0_rdata=0xDEADBEEF, p1_ready never asserted.
REQ-034 Single write: p1 write of 0xA5A5A5A5, mask 0xF, addr 0x100 -> sd_din=0xA5A5A5A5, sd_wmask=0xF until sd_ready, then sd_wmask=0, one p1_ready pulse.
REQ-035 Contention: both ports request continuously for 4 transactions -> RR build grants p0,p1,p0,p1 starting after reset; non-RR build grants p0 four times while p1 waits.
REQ-036 Slow release: sd_ready held high 3 cycles after sd_valid drops -> DONE is delayed until sd_ready=0 and no new grant is issued while sd_ready=1.
REQ-037 Mid-transfer reset: reset pulsed in REQ with sd_ready=0 -> sd_valid=0 next cycle, no pN_ready, and the next grant occurs only with sd_ready=0.
